// File: rtl/main_mem_burst.sv
// main_mem_burst: big-endian, byte-addressed RAM mapped at BASE_ADDR.
// Serves single-word and fixed-length (1/4/8/16 word) read and write bursts
// over one port, with busy, per-beat d_valid and an err pulse for rejected
// requests.
// Optional build macro: MAINMEM_ALIGN_CHECK_EN -- when defined, addresses
// that are not word aligned are rejected; otherwise the low address bits are
// dropped and the access is performed aligned.
module main_mem_burst #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                MEM_BYTES      = 1048576,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h80020000,
  parameter int                MAX_BURST_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        acc_size_i,
  input  logic [DATA_W-1:0] d_in_i,
  output logic [DATA_W-1:0] d_out_o,
  output logic              d_valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = MAX_BURST_LOG2 + 1;
  // Range arithmetic is done wide enough that offset + burst bytes never wraps.
  localparam int EXT_W = ADDR_W + 16;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Storage: zero at time 0, never cleared by reset.
  logic [7:0] mem_q [0:MEM_BYTES-1] = '{default: 8'h00};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] addr_al;
  logic [ADDR_W-1:0] off_full;
  logic [CNT_W-1:0]  len_req;
  logic              in_range;
  logic              req_ok;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic              unused_off_hi;

`ifdef MAINMEM_ALIGN_CHECK_EN
  assign addr_al = addr_i;
  assign req_ok  = in_range && ((addr_i & ALIGN_MASK) == '0);
`else
  assign addr_al = addr_i & ~ALIGN_MASK;
  assign req_ok  = in_range;
`endif

  // Decode the burst length code into a word count.
  always_comb begin
    len_req = CNT_W'(1);
    case (acc_size_i)
      2'd0:    len_req = CNT_W'(1);
      2'd1:    len_req = CNT_W'(4);
      2'd2:    len_req = CNT_W'(8);
      default: len_req = CNT_W'(16);
    endcase
  end

  assign off_full = addr_al - BASE_ADDR;
  assign in_range = (addr_al >= BASE_ADDR) &&
                    ((EXT_W'(off_full) + EXT_W'(len_req) * EXT_W'(BPW)) <= EXT_W'(MEM_BYTES));
  // Offsets above the array size are already excluded by in_range.
  assign unused_off_hi = ^off_full[ADDR_W-1:IDX_W];

  // Requests are only looked at while idle; busy masks them otherwise.
  assign accept = en_i && (state_q == S_IDLE);
  // Reset wins over any pending beat so an aborted burst writes nothing more.
  assign wr_en  = !rst_i && ((accept && req_ok && wren_i) || (state_q == S_WRITE));
  assign rd_en  = !rst_i && ((accept && req_ok && !wren_i) ||
                             ((state_q == S_READ) && (cnt_q != len_q)));
  // Beat 0 is addressed straight from the request; later beats from the pointer.
  assign mem_idx = (state_q == S_IDLE) ? off_full[IDX_W-1:0] : ptr_q;

  // Assemble one big-endian word from the addressed bytes.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BPW; i++) begin
      rd_word[DATA_W-1-8*i -: 8] = mem_q[mem_idx + IDX_W'(i)];
    end
  end

  // Write one big-endian word per beat; lowest address takes the MSBs.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < BPW; i++) begin
        mem_q[mem_idx + IDX_W'(i)] <= d_in_i[DATA_W-1-8*i -: 8];
      end
    end
  end

  // Next-state logic for the burst FSM, beat counter and output registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    d_out_d   = d_out_q;
    d_valid_d = rd_en;
    err_d     = accept && !req_ok;
    if (rd_en) begin
      d_out_d = rd_word;
    end
    case (state_q)
      S_IDLE: begin
        if (accept && req_ok) begin
          len_d = len_req;
          ptr_d = off_full[IDX_W-1:0] + IDX_W'(BPW);
          cnt_d = CNT_W'(1);
          if (!wren_i) begin
            state_d = S_READ;
          end else if (len_req != CNT_W'(1)) begin
            state_d = S_WRITE;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_WRITE: begin
        ptr_d = ptr_q + IDX_W'(BPW);
        if (cnt_q == len_q - CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        // One extra cycle after the last fetch keeps busy over the last beat.
        if (cnt_q == len_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ptr_d = ptr_q + IDX_W'(BPW);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      ptr_q     <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      err_q     <= err_d;
    end
  end

  assign d_out_o   = d_out_q;
  assign d_valid_o = d_valid_q;
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_main_mem_burst.sv
// Testbench for main_mem_burst: directed requests, a cycle-indexed expectation
// model derived from the burst timing rules, and literal spot checks.
module tb_main_mem_burst;

  localparam int          MEM  = 1048576;
  localparam logic [31:0] BASE = 32'h80020000;
  localparam int          NC   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  acc_size = '0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        d_valid;
  logic        busy;
  logic        err;

  main_mem_burst #(
    .ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM), .BASE_ADDR(BASE), .MAX_BURST_LOG2(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .wren_i(wren), .addr_i(addr),
    .acc_size_i(acc_size), .d_in_i(d_in), .d_out_o(d_out), .d_valid_o(d_valid),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: byte memory plus per-cycle expected outputs.
  bit [7:0]    mm [MEM];
  bit          e_busy [NC];
  bit          e_valid [NC];
  bit          e_err [NC];
  bit          e_rst [NC];
  logic [31:0] e_data [NC];
  logic [31:0] last_d = '0;
  logic [31:0] ed_c;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cap [$];
  int          cap_cyc [$];
  int          busy_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] wbuf [16];

  function automatic logic [31:0] mrd(input int off);
    return {mm[off], mm[off+1], mm[off+2], mm[off+3]};
  endfunction

  task automatic mwr(input int off, input logic [31:0] w);
    mm[off]   = w[31:24];
    mm[off+1] = w[23:16];
    mm[off+2] = w[15:8];
    mm[off+3] = w[7:0];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NC) begin
      if (e_rst[cyc])        ed_c = '0;
      else if (e_valid[cyc]) ed_c = e_data[cyc];
      else                   ed_c = last_d;
      last_d = ed_c;
      chk("busy",    32'(busy),    32'(e_busy[cyc]));
      chk("d_valid", 32'(d_valid), 32'(e_valid[cyc]));
      chk("err",     32'(err),     32'(e_err[cyc]));
      chk("d_out",   d_out,        ed_c);
      if (d_valid) begin
        cap.push_back(d_out);
        cap_cyc.push_back(cyc);
      end
      if (busy) busy_cnt++;
      if (err)  err_cnt++;
    end
  end

  // Issue one request at the current cycle and record what must follow.
  // poke: beat index (1..len) during a read at which a stray en is pulsed.
  task automatic req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                     input int poke, output int t);
    int                len;
    int                off;
    longint unsigned   aa;
    bit                ok;
    len = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
`ifdef MAINMEM_ALIGN_CHECK_EN
    aa = longint'(a);
    ok = (a[1:0] == 2'b00);
`else
    aa = longint'({a[31:2], 2'b00});
    ok = 1'b1;
`endif
    ok = ok && (aa >= longint'(BASE)) &&
         ((aa - longint'(BASE) + longint'(len * 4)) <= longint'(MEM));
    t = cyc;
    en = 1'b1; wren = wr; addr = a; acc_size = sz; d_in = wbuf[0];
    if (!ok) begin
      e_err[t+1] = 1'b1;
      tick();
      en = 1'b0;
      return;
    end
    off = int'(aa - longint'(BASE));
    if (wr) begin
      mwr(off, wbuf[0]);
      for (int c = t + 1; c <= t + len - 1; c++) e_busy[c] = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 1; k < len; k++) begin
        d_in = wbuf[k];
        mwr(off + 4 * k, wbuf[k]);
        tick();
      end
    end else begin
      for (int k = 0; k < len; k++) begin
        e_valid[t+1+k] = 1'b1;
        e_data[t+1+k]  = mrd(off + 4 * k);
      end
      for (int c = t + 1; c <= t + len; c++) e_busy[c] = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 1; k <= len; k++) begin
        if (k == poke) begin
          en = 1'b1; wren = 1'b1; addr = 32'h80020300; acc_size = 2'd3;
        end else begin
          en = 1'b0;
        end
        tick();
      end
      en = 1'b0;
    end
  endtask

  initial begin
    int t;
    int t2;
    e_rst[1] = 1'b1; e_rst[2] = 1'b1; e_rst[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("reset_busy",  32'(busy),    32'd0);
    chk("reset_valid", 32'(d_valid), 32'd0);
    chk("reset_err",   32'(err),     32'd0);
    chk("reset_dout",  d_out,        32'h0);

    // Single-word write then read back.
    busy_cnt = 0;
    wbuf[0] = 32'hDEADBEEF;
    req(1'b1, 32'h80020000, 2'd0, 0, t);
    repeat (2) tick();
    chk("single_wr_busy_cycles", 32'(busy_cnt), 32'd0);
    cap.delete(); cap_cyc.delete();
    req(1'b0, 32'h80020000, 2'd0, 0, t);
    repeat (2) tick();
    chk("single_rd_beats", 32'(cap.size()), 32'd1);
    chk("single_rd_data",  cap[0], 32'hDEADBEEF);
    chk("single_rd_msb",   32'(cap[0][31:24]), 32'h000000DE);
    chk("single_rd_when",  32'(cap_cyc[0]), 32'(t + 1));
    chk("model_byte0",     32'(mm[0]), 32'h000000DE);

    // 8-word burst write and read back.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'(k + 1);
    busy_cnt = 0;
    req(1'b1, 32'h80020100, 2'd2, 0, t);
    repeat (2) tick();
    chk("burst8_wr_busy_cycles", 32'(busy_cnt), 32'd7);
    busy_cnt = 0;
    cap.delete(); cap_cyc.delete();
    req(1'b0, 32'h80020100, 2'd2, 0, t);
    repeat (2) tick();
    chk("burst8_rd_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("burst8_rd_beats", 32'(cap.size()), 32'd8);
    for (int k = 0; k < 8 && k < cap.size(); k++) chk("burst8_rd_data", cap[k], 32'(k + 1));
    if (cap.size() == 8) chk("burst8_rd_span", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);

    // Range checks.
    err_cnt = 0; busy_cnt = 0;
    wbuf[0] = 32'h11111111;
    req(1'b1, 32'h8001FFFC, 2'd0, 0, t);
    req(1'b0, BASE + 32'(MEM) - 32'd32, 2'd3, 0, t);
    req(1'b0, 32'hFFFFFFF0, 2'd3, 0, t);
    repeat (2) tick();
    chk("range_err_count", 32'(err_cnt), 32'd3);
    chk("range_busy_cycles", 32'(busy_cnt), 32'd0);
    wbuf[0] = 32'h12345678;
    req(1'b1, BASE + 32'(MEM) - 32'd4, 2'd0, 0, t);
    cap.delete(); cap_cyc.delete();
    req(1'b0, BASE + 32'(MEM) - 32'd4, 2'd0, 0, t);
    repeat (2) tick();
    chk("top_word_beats", 32'(cap.size()), 32'd1);
    chk("top_word_data", cap[0], 32'h12345678);
    chk("top_word_err_count", 32'(err_cnt), 32'd3);

    // Stray en mid-read is ignored; back-to-back reads have one idle cycle.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h200 + 32'(k);
    req(1'b1, 32'h80020200, 2'd2, 0, t);
    cap.delete(); cap_cyc.delete();
    req(1'b0, 32'h80020200, 2'd1, 2, t);
    req(1'b0, 32'h80020210, 2'd1, 0, t2);
    repeat (2) tick();
    chk("b2b_beats", 32'(cap.size()), 32'd8);
    for (int k = 0; k < 8 && k < cap.size(); k++) chk("b2b_data", cap[k], 32'h200 + 32'(k));
    if (cap.size() == 8) begin
      chk("b2b_gap", 32'(cap_cyc[4] - cap_cyc[3]), 32'd2);
      chk("b2b_first_run", 32'(cap_cyc[3] - cap_cyc[0]), 32'd3);
    end

    // Reset in the middle of a 16-word write.
    for (int k = 0; k < 16; k++) wbuf[k] = 32'h1000 + 32'(k);
    req(1'b1, 32'h80020400, 2'd3, 0, t);
    t = cyc;
    en = 1'b1; wren = 1'b1; addr = 32'h80020400; acc_size = 2'd3; d_in = 32'hA5A5A5A5;
    mwr(32'h400, 32'hA5A5A5A5);
    for (int c = t + 1; c <= t + 15; c++) e_busy[c] = 1'b1;
    tick();
    en = 1'b0;
    mwr(32'h404, 32'hA5A5A5A5);
    tick();
    rst = 1'b1;
    for (int c = t + 3; c <= t + 20; c++) begin
      e_busy[c] = 1'b0; e_valid[c] = 1'b0; e_err[c] = 1'b0;
    end
    e_rst[t+3] = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_valid", 32'(d_valid), 32'd0);
    chk("abort_err",   32'(err),     32'd0);
    chk("abort_dout",  d_out,        32'h0);
    tick();
    cap.delete(); cap_cyc.delete();
    req(1'b0, 32'h80020400, 2'd3, 0, t);
    repeat (2) tick();
    chk("abort_rd_beats", 32'(cap.size()), 32'd16);
    if (cap.size() == 16) begin
      chk("abort_beat0",  cap[0],  32'hA5A5A5A5);
      chk("abort_beat1",  cap[1],  32'hA5A5A5A5);
      chk("abort_beat2",  cap[2],  32'h00001002);
      chk("abort_beat15", cap[15], 32'h0000100F);
    end

    // Misaligned request.
    err_cnt = 0;
    cap.delete(); cap_cyc.delete();
    req(1'b0, 32'h80020002, 2'd0, 0, t);
    repeat (2) tick();
`ifdef MAINMEM_ALIGN_CHECK_EN
    chk("misalign_err_count", 32'(err_cnt), 32'd1);
    chk("misalign_beats", 32'(cap.size()), 32'd0);
`else
    chk("misalign_err_count", 32'(err_cnt), 32'd0);
    chk("misalign_beats", 32'(cap.size()), 32'd1);
    if (cap.size() == 1) chk("misalign_data", cap[0], 32'hDEADBEEF);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound the run in case the design stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
